// File: rtl/gpio_pkg.sv
// Register map shared by the GPIO controller and anything that talks to it.
package gpio_pkg;
  localparam int ADDR_BITS = 4;

  localparam logic [ADDR_BITS-1:0] REG_EN   = 4'd0;
  localparam logic [ADDR_BITS-1:0] REG_DIR  = 4'd1;
  localparam logic [ADDR_BITS-1:0] REG_IN   = 4'd2;
  localparam logic [ADDR_BITS-1:0] REG_OUT  = 4'd3;
  localparam logic [ADDR_BITS-1:0] REG_SET  = 4'd4;
  localparam logic [ADDR_BITS-1:0] REG_CLR  = 4'd5;
  localparam logic [ADDR_BITS-1:0] REG_IER  = 4'd6;
  localparam logic [ADDR_BITS-1:0] REG_IEF  = 4'd7;
  localparam logic [ADDR_BITS-1:0] REG_STAT = 4'd8;
endpackage

// File: rtl/gpio_ctrl_if.sv
// Strobe/rw memory-mapped bus plus interrupt line; master drives accesses, slave answers.
interface gpio_ctrl_if;
  logic        strobe;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        irq;

  modport master (output strobe, rw, addr, data_i, input data_o, irq);
  modport slave  (input strobe, rw, addr, data_i, output data_o, irq);
endinterface

// File: rtl/gpio_sync.sv
// One-pin input synchroniser (SYNC_STAGES flops), plus a DEB_CYCLES debounce filter
// when GPIO_DEBOUNCE_EN is defined; no backpressure, latency SYNC_STAGES (+DEB_CYCLES).
module gpio_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic sync_o
);
  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) chain_q <= '0;
    else        chain_q <= {chain_q[SYNC_STAGES-2:0], pin_i};
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;

  // Counter only runs while the synced value disagrees; any agreement restarts it.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (chain_q[SYNC_STAGES-1] != deb_q) begin
      if (cnt_q == CNT_LAST) deb_d = chain_q[SYNC_STAGES-1];
      else                   cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign sync_o = deb_q;
`else
  localparam int unused_deb_cycles = DEB_CYCLES;
  assign sync_o = chain_q[SYNC_STAGES-1];
`endif
endmodule

// File: rtl/gpio_ctrl.sv
// GPIO controller: EN/DIR/OUT with atomic SET/CLR, edge irqs with W1C STAT; reads return
// one cycle after strobe, writes land on the strobe edge, never stalls. Debounce: GPIO_DEBOUNCE_EN.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int COUNT       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             reset,
  gpio_ctrl_if.slave       bus,
  inout  wire  [COUNT-1:0] gpio
);
  logic [COUNT-1:0] en_q,   en_d;
  logic [COUNT-1:0] dir_q,  dir_d;
  logic [COUNT-1:0] out_q,  out_d;
  logic [COUNT-1:0] ier_q,  ier_d;
  logic [COUNT-1:0] ief_q,  ief_d;
  logic [COUNT-1:0] stat_q, stat_d;
  logic [COUNT-1:0] prev_q;
  logic [31:0]      data_q, data_d;

  logic [COUNT-1:0] s;
  logic [COUNT-1:0] in_mask, rise, fall, w1c, wdat, rdat;
  logic [ADDR_BITS-1:0] idx;
  logic             wr, rd;

  for (genvar i = 0; i < COUNT; i++) begin : g_pin
    gpio_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_sync (
      .clk   (clk),
      .reset (reset),
      .pin_i (gpio[i]),
      .sync_o(s[i])
    );
    assign gpio[i] = (en_q[i] & dir_q[i]) ? out_q[i] : 1'bz;
  end

  logic unused_addr;
  assign unused_addr = ^bus.addr[31:ADDR_BITS];
  if (COUNT < 32) begin : g_unused_data
    logic unused_data;
    assign unused_data = ^bus.data_i[31:COUNT];
  end

  assign wr      = bus.strobe & bus.rw;
  assign rd      = bus.strobe & ~bus.rw;
  assign idx     = bus.addr[ADDR_BITS-1:0];
  assign wdat    = bus.data_i[COUNT-1:0];
  // prev follows s unconditionally, so masked pins never leave a stale edge behind.
  assign in_mask = en_q & ~dir_q;
  assign rise    = s & ~prev_q & in_mask & ier_q;
  assign fall    = ~s & prev_q & in_mask & ief_q;

  always_comb begin
    en_d   = en_q;
    dir_d  = dir_q;
    out_d  = out_q;
    ier_d  = ier_q;
    ief_d  = ief_q;
    data_d = data_q;
    w1c    = '0;
    rdat   = '0;
    if (wr) begin
      case (idx)
        REG_EN:   en_d  = wdat;
        REG_DIR:  dir_d = wdat;
        REG_OUT:  out_d = wdat;
        REG_SET:  out_d = out_q | wdat;
        REG_CLR:  out_d = out_q & ~wdat;
        REG_IER:  ier_d = wdat;
        REG_IEF:  ief_d = wdat;
        REG_STAT: w1c   = wdat;
        default:  ;
      endcase
    end
    // New edges are ORed in after the clear so a coincident W1C cannot drop them.
    stat_d = (stat_q & ~w1c) | rise | fall;
    if (rd) begin
      case (idx)
        REG_EN:   rdat = en_q;
        REG_DIR:  rdat = dir_q;
        REG_IN:   rdat = s & in_mask;
        REG_OUT:  rdat = out_q;
        REG_IER:  rdat = ier_q;
        REG_IEF:  rdat = ief_q;
        REG_STAT: rdat = stat_q;
        default:  rdat = '0;
      endcase
      data_d = 32'(rdat);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q   <= '0;
      dir_q  <= '0;
      out_q  <= '0;
      ier_q  <= '0;
      ief_q  <= '0;
      stat_q <= '0;
      prev_q <= '0;
      data_q <= '0;
    end else begin
      en_q   <= en_d;
      dir_q  <= dir_d;
      out_q  <= out_d;
      ier_q  <= ier_d;
      ief_q  <= ief_d;
      stat_q <= stat_d;
      prev_q <= s;
      data_q <= data_d;
    end
  end

  assign bus.data_o = data_q;
  assign bus.irq    = |stat_q;
endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: register table plus hand sequences for pin timing, irq and reset.
module tb_gpio_ctrl;
  import gpio_pkg::*;

  localparam int COUNT = 8;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = SYNC + 1 + DEB;
`else
  localparam int LAT = SYNC + 1;
`endif
  localparam int NV = 23;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [COUNT-1:0] tb_oe, tb_val;
  wire  [COUNT-1:0] gpio;
  int total = 0;
  int bad = 0;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  gpio_ctrl_if bus();

  for (genvar i = 0; i < COUNT; i++) begin : g_drv
    assign gpio[i] = tb_oe[i] ? tb_val[i] : 1'bz;
  end

  gpio_ctrl #(
    .COUNT      (COUNT),
    .SYNC_STAGES(SYNC),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus),
    .gpio (gpio)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.strobe = 1'b1; bus.rw = 1'b1; bus.addr = a; bus.data_i = d;
    @(negedge clk);
    bus.strobe = 1'b0; bus.rw = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.strobe = 1'b1; bus.rw = 1'b0; bus.addr = a;
    @(negedge clk);
    bus.strobe = 1'b0;
    d = bus.data_o;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tb_oe = '0; tb_val = '0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    bus.strobe = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.data_i = '0;
    tb_oe = '0; tb_val = '0; rst_n = 1'b0;

    vecs[0]  = '{1'b1, 32'(REG_EN),   32'hFFFF_FFFF, 32'h0};
    vecs[1]  = '{1'b0, 32'(REG_EN),   32'h0, 32'h0000_00FF};
    vecs[2]  = '{1'b1, 32'(REG_DIR),  32'hF0, 32'h0};
    vecs[3]  = '{1'b0, 32'(REG_DIR),  32'h0, 32'hF0};
    vecs[4]  = '{1'b1, 32'(REG_OUT),  32'h05, 32'h0};
    vecs[5]  = '{1'b0, 32'(REG_OUT),  32'h0, 32'h05};
    vecs[6]  = '{1'b1, 32'(REG_SET),  32'h82, 32'h0};
    vecs[7]  = '{1'b0, 32'(REG_OUT),  32'h0, 32'h87};
    vecs[8]  = '{1'b1, 32'(REG_CLR),  32'h05, 32'h0};
    vecs[9]  = '{1'b0, 32'(REG_OUT),  32'h0, 32'h82};
    vecs[10] = '{1'b0, 32'(REG_SET),  32'h0, 32'h0};
    vecs[11] = '{1'b0, 32'(REG_CLR),  32'h0, 32'h0};
    vecs[12] = '{1'b1, 32'(REG_IER),  32'h3C, 32'h0};
    vecs[13] = '{1'b0, 32'(REG_IER),  32'h0, 32'h3C};
    vecs[14] = '{1'b1, 32'(REG_IEF),  32'hC3, 32'h0};
    vecs[15] = '{1'b0, 32'(REG_IEF),  32'h0, 32'hC3};
    vecs[16] = '{1'b1, 32'd9,         32'hFF, 32'h0};
    vecs[17] = '{1'b0, 32'd9,         32'h0, 32'h0};
    vecs[18] = '{1'b1, 32'h10,        32'h11, 32'h0};
    vecs[19] = '{1'b0, 32'(REG_EN),   32'h0, 32'h11};
    vecs[20] = '{1'b0, 32'hF,         32'h0, 32'h0};
    vecs[21] = '{1'b1, 32'(REG_STAT), 32'hFF, 32'h0};
    vecs[22] = '{1'b0, 32'(REG_STAT), 32'h0, 32'h0};

    // Reset state
    idle(2);
    check("rst_data_o", bus.data_o, 32'h0);
    check("rst_irq", 32'(bus.irq), 32'h0);
    rst_n = 1'b1;
    idle(1);
    for (int a = 0; a < 16; a++) begin
      rd(32'(a), d);
      check($sformatf("rst_rd%0d", a), d, 32'h0);
    end
    tb_oe = '1; tb_val = 8'hA5;
    idle(1);
    check("rst_z_a5", 32'(gpio), 32'hA5);
    tb_val = 8'h5A;
    idle(1);
    check("rst_z_5a", 32'(gpio), 32'h5A);
    tb_oe = '0;

    // Register table
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].data);
      else begin
        rd(vecs[i].addr, d);
        check($sformatf("vec%0d", i), d, vecs[i].exp);
      end
    end

    // Output drive, SET/CLR, data_o hold
    do_reset();
    wr(32'(REG_EN), 32'hF);
    wr(32'(REG_DIR), 32'hF);
    wr(32'(REG_OUT), 32'h5);
    check("out_0101", 32'(gpio[3:0]), 32'h5);
    wr(32'(REG_SET), 32'h2);
    check("set_0111", 32'(gpio[3:0]), 32'h7);
    wr(32'(REG_CLR), 32'h4);
    check("clr_0011", 32'(gpio[3:0]), 32'h3);
    rd(32'(REG_OUT), d);
    check("out_rd", d, 32'h3);
    idle(2);
    check("data_o_hold_idle", bus.data_o, 32'h3);
    wr(32'(REG_OUT), 32'h0);
    check("data_o_hold_wr", bus.data_o, 32'h3);

    // Input latency
    do_reset();
    tb_oe = 8'h01; tb_val = 8'h00;
    wr(32'(REG_EN), 32'h1);
    idle(LAT + 1);
    tb_val = 8'h01;
    for (int n = 1; n <= LAT + 2; n++) begin
      rd(32'(REG_IN), d);
      check($sformatf("in_lat%0d", n), d, (n >= LAT) ? 32'h1 : 32'h0);
    end

    // Rising-edge irq and W1C
    do_reset();
    tb_oe = 8'h01; tb_val = 8'h00;
    wr(32'(REG_EN), 32'h1);
    wr(32'(REG_IER), 32'h1);
    idle(LAT);
    tb_val = 8'h01;
    for (int n = 1; n <= LAT + 1; n++) begin
      idle(1);
      check($sformatf("irq_lat%0d", n), 32'(bus.irq), (n >= LAT) ? 32'h1 : 32'h0);
    end
    rd(32'(REG_STAT), d);
    check("stat_rise", d, 32'h1);
    wr(32'(REG_STAT), 32'h1);
    check("irq_cleared", 32'(bus.irq), 32'h0);
    rd(32'(REG_STAT), d);
    check("stat_cleared", d, 32'h0);

    // Falling edge
    wr(32'(REG_IEF), 32'h1);
    tb_val = 8'h00;
    idle(LAT);
    rd(32'(REG_STAT), d);
    check("stat_fall", d, 32'h1);
    wr(32'(REG_STAT), 32'h1);
    rd(32'(REG_STAT), d);
    check("stat_fall_clr", d, 32'h0);

    // W1C colliding with a new rise on the same bit
    tb_val = 8'h01;
    idle(LAT - 1);
    wr(32'(REG_STAT), 32'h1);
    check("collide_irq", 32'(bus.irq), 32'h1);
    rd(32'(REG_STAT), d);
    check("collide_stat", d, 32'h1);
    wr(32'(REG_STAT), 32'h1);
    rd(32'(REG_STAT), d);
    check("collide_after_clr", d, 32'h0);

    // Disabled pin: no edges, and no spurious edge on re-enable
    wr(32'(REG_EN), 32'h0);
    tb_val = 8'h00;
    idle(LAT + 2);
    tb_val = 8'h01;
    idle(LAT + 2);
    rd(32'(REG_STAT), d);
    check("disabled_no_edge", d, 32'h0);
    wr(32'(REG_EN), 32'h1);
    idle(LAT + 2);
    rd(32'(REG_STAT), d);
    check("reenable_no_edge", d, 32'h0);

    // Output pin: its own fall is masked, and switching back to input stays quiet
    tb_oe = 8'h00;
    wr(32'(REG_DIR), 32'h1);
    idle(LAT + 2);
    wr(32'(REG_DIR), 32'h0);
    idle(LAT + 2);
    rd(32'(REG_STAT), d);
    check("output_no_edge", d, 32'h0);

    // Async reset mid-write with outputs driven and an irq pending
    do_reset();
    wr(32'(REG_EN), 32'h1F);
    wr(32'(REG_DIR), 32'h0F);
    wr(32'(REG_OUT), 32'h0F);
    wr(32'(REG_IER), 32'h10);
    tb_oe = 8'h10; tb_val = 8'h00;
    idle(LAT);
    check("pre_rst_drive", 32'(gpio[3:0]), 32'hF);
    tb_val = 8'h10;
    idle(LAT + 1);
    check("pre_rst_irq", 32'(bus.irq), 32'h1);
    bus.strobe = 1'b1; bus.rw = 1'b1; bus.addr = 32'(REG_OUT); bus.data_i = 32'h0;
    tb_oe = 8'h1F;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gpio_z", 32'(gpio[3:0]), 32'h0);
    check("arst_irq", 32'(bus.irq), 32'h0);
    @(negedge clk);
    bus.strobe = 1'b0; bus.rw = 1'b0;
    idle(1);
    rst_n = 1'b1;
    tb_oe = '0;
    idle(1);
    rd(32'(REG_EN), d);
    check("arst_en", d, 32'h0);
    rd(32'(REG_OUT), d);
    check("arst_out", d, 32'h0);
    rd(32'(REG_STAT), d);
    check("arst_stat", d, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
    // A pulse shorter than the debounce window never reaches STAT
    tb_oe = 8'h01; tb_val = 8'h00;
    wr(32'(REG_EN), 32'h1);
    wr(32'(REG_IER), 32'h1);
    idle(LAT + 2);
    tb_val = 8'h01;
    idle(2);
    tb_val = 8'h00;
    idle(LAT + 4);
    rd(32'(REG_STAT), d);
    check("deb_pulse_stat", d, 32'h0);
    rd(32'(REG_IN), d);
    check("deb_pulse_in", d, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
